// File: rtl/easy_fifo_axis_rr_arb.sv
// easy_fifo_axis_rr_arb
// Round-robin AXI-Stream arbiter: merges NUM_SRC stream sources onto one AXIS
// output (typically the write side of a sync AXIS FIFO). A two-state grant FSM
// picks one requester, passes its beats straight through, and re-arbitrates on
// a tlast beat or after MAX_BURST beats. The granted index is exported as
// m_axis_tid.
//
// Optional feature macro: EASY_FIFO_ARB_PKT_LOCK_EN
//   defined   -> grant is released only on a tlast beat (packets stay atomic)
//   undefined -> grant is released on tlast or at MAX_BURST beats
//
// Handshake: a beat transfers on any cycle where valid and ready are both 1.
// valid/data/last of the granted source are routed combinationally to the
// output, and m_axis_tready is routed combinationally back to that source
// only; every other s_axis_tready bit stays 0.
module easy_fifo_axis_rr_arb #(
   parameter int DWIDTH    = 32,
   parameter int NUM_SRC   = 4,
   parameter int MAX_BURST = 16,
   localparam int IDW      = $clog2(NUM_SRC),
   localparam int CW       = $clog2(MAX_BURST) + 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_SRC*DWIDTH-1:0]   s_axis_tdata,
   input  logic [NUM_SRC-1:0]          s_axis_tvalid,
   input  logic [NUM_SRC-1:0]          s_axis_tlast,
   output logic [NUM_SRC-1:0]          s_axis_tready,
   output logic [DWIDTH-1:0]           m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic                        m_axis_tlast,
   output logic [IDW-1:0]              m_axis_tid,
   input  logic                        m_axis_tready,
   output logic                        busy,
   output logic                        dbg_state_o
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

`ifdef EASY_FIFO_ARB_PKT_LOCK_EN
   localparam bit PKT_LOCK = 1'b1;
`else
   localparam bit PKT_LOCK = 1'b0;
`endif

   state_t           state_q, state_d;
   logic [IDW-1:0]   grant_q, grant_d;
   logic [IDW-1:0]   last_grant_q, last_grant_d;
   logic [CW-1:0]    beat_cnt_q, beat_cnt_d;

   logic [DWIDTH-1:0] src_data [NUM_SRC];
   logic              scan_hit;
   logic [IDW-1:0]    scan_idx;
   logic              grant_act;
   logic              beat;
   logic              rel_grant;
   logic [CW-1:0]     cnt_inc;

   // Split the flat source data bus into one word per source.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         src_data[i] = s_axis_tdata[i*DWIDTH +: DWIDTH];
      end
   end

   // Round-robin scan: first valid source after last_grant, wrapping.
   // Iterating from the farthest candidate down lets the nearest one win.
   always_comb begin : scan_proc
      int cand;
      scan_hit = 1'b0;
      scan_idx = '0;
      cand     = 0;
      for (int i = NUM_SRC; i >= 1; i--) begin
         cand = (int'(last_grant_q) + i) % NUM_SRC;
         if (s_axis_tvalid[cand[IDW-1:0]]) begin
            scan_hit = 1'b1;
            scan_idx = cand[IDW-1:0];
         end
      end
   end

   // Zero-latency pass-through from the granted source; all idle otherwise.
   always_comb begin
      grant_act     = (state_q == ST_GRANT);
      m_axis_tdata  = src_data[grant_q];
      m_axis_tvalid = grant_act & s_axis_tvalid[grant_q];
      m_axis_tlast  = grant_act & s_axis_tlast[grant_q];
      s_axis_tready = '0;
      if (grant_act) begin
         s_axis_tready[grant_q] = m_axis_tready;
      end
   end

   // Beat accounting and release decision for the current grant.
   always_comb begin
      beat      = m_axis_tvalid & m_axis_tready;
      cnt_inc   = beat_cnt_q + 1'b1;
      rel_grant = beat & (s_axis_tlast[grant_q] |
                          (!PKT_LOCK && (cnt_inc == CW'(MAX_BURST))));
   end

   // Grant FSM next-state logic.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (scan_hit) begin
               grant_d = scan_idx;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (rel_grant) begin
               last_grant_d = grant_q;
               beat_cnt_d   = '0;
               state_d      = ST_IDLE;
            end else if (beat && (beat_cnt_q != CW'(MAX_BURST))) begin
               // Saturates at MAX_BURST; only reachable with packet lock.
               beat_cnt_d = cnt_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; last_grant resets to the top index so source 0 goes first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= IDW'(NUM_SRC - 1);
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

   assign m_axis_tid  = grant_q;
   assign busy        = (state_q == ST_GRANT);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_easy_fifo_axis_rr_arb.sv
// Testbench for easy_fifo_axis_rr_arb (DWIDTH=16, NUM_SRC=4, MAX_BURST=4).
// A transaction-level model (round-robin pointer, current owner, beat count)
// predicts outputs each cycle; per-source expected queues check beat data.
module tb_easy_fifo_axis_rr_arb;

   localparam int DW = 16;
   localparam int NS = 4;
   localparam int MB = 4;

`ifdef EASY_FIFO_ARB_PKT_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic [NS*DW-1:0]  s_axis_tdata;
   logic [NS-1:0]     s_axis_tvalid;
   logic [NS-1:0]     s_axis_tlast;
   logic [NS-1:0]     s_axis_tready;
   logic [DW-1:0]     m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic [1:0]        m_axis_tid;
   logic              m_axis_tready;
   logic              busy;
   logic              dbg_state_o;

   easy_fifo_axis_rr_arb #(
      .DWIDTH   (DW),
      .NUM_SRC  (NS),
      .MAX_BURST(MB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tid    (m_axis_tid),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
      .dbg_state_o   (dbg_state_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Source beat queues ({last, data}) feeding the drivers, and the
   // scoreboard's per-source expected queues.
   logic [DW:0]     src_q [NS][$];
   logic [DW:0]     exp_q [NS][$];
   bit              held [NS];
   int unsigned     vprob = 100;
   int unsigned     rprob = 100;
   bit              rmode = 1'b0;
   bit              tog   = 1'b0;
   bit              mon_en = 1'b0;

   // Reference model state: owner (-1 = nobody), previous owner, beats so far.
   int              m_gnt;
   int              m_last;
   int              m_cnt;
   logic [1:0]      m_tid;
   int              tid_log[$];
   logic [DW-1:0]   data_log[$];

   task automatic model_reset();
      m_gnt  = -1;
      m_last = NS - 1;
      m_cnt  = 0;
      m_tid  = 2'd0;
   endtask

   task automatic start_reset();
      mon_en = 1'b0;
      rst    = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tvalid = '0;
      s_axis_tlast  = '0;
      m_axis_tready = 1'b0;
      for (int i = 0; i < NS; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
         held[i] = 1'b0;
      end
      tid_log.delete();
      data_log.delete();
      model_reset();
   endtask

   task automatic finish_reset();
      s_axis_tvalid = '0;
      m_axis_tready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic add_beat(input int s, input logic [DW-1:0] d, input logic l);
      src_q[s].push_back({l, d});
      exp_q[s].push_back({l, d});
   endtask

   task automatic add_pkt(input int s, input int len);
      for (int b = 0; b < len; b++) begin
         add_beat(s, DW'($urandom), (b == len - 1));
      end
   endtask

   // ---------------- drivers ----------------
   task automatic drive();
      logic [DW:0] f;
      for (int i = 0; i < NS; i++) begin
         if (!held[i]) begin
            if (src_q[i].size() > 0 && $urandom_range(0, 99) < vprob) begin
               f = src_q[i][0];
               s_axis_tvalid[i]           = 1'b1;
               s_axis_tdata[i*DW +: DW]   = f[DW-1:0];
               s_axis_tlast[i]            = f[DW];
            end else begin
               s_axis_tvalid[i]           = 1'b0;
               s_axis_tlast[i]            = 1'b0;
               s_axis_tdata[i*DW +: DW]   = DW'($urandom);
            end
         end
      end
      if (rmode) begin
         tog = ~tog;
         m_axis_tready = tog;
      end else begin
         m_axis_tready = ($urandom_range(0, 99) < rprob);
      end
   endtask

   // One clock: drive after the rising edge, retire handshakes on the falling edge.
   task automatic step();
      drive();
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
         if (s_axis_tvalid[i] && s_axis_tready[i]) begin
            void'(src_q[i].pop_front());
            held[i] = 1'b0;
         end else begin
            held[i] = s_axis_tvalid[i];
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NS; i++) begin
         if (src_q[i].size() != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic run_until_drained(input int budget, output int cycles);
      cycles = 0;
      forever begin
         step();
         cycles++;
         if (all_empty() && m_gnt < 0) break;
         if (cycles >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required drain within %0d", cycles, budget);
            break;
         end
      end
   endtask

   // ---------------- scoreboard / reference model ----------------
   logic [DW:0]   mon_e;
   logic [NS-1:0] mon_er;
   logic [1:0]    mon_g;
   int            mon_c;

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (m_gnt < 0) begin
            checks++;
            if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 ||
                s_axis_tready !== '0 || m_axis_tid !== m_tid) begin
               errors++;
               $display("FAIL idle_outputs t=%0t: busy=%b valid=%b last=%b ready=%b tid=%0d, required 0 0 0 0000 tid=%0d",
                        $time, busy, m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tid, m_tid);
            end
            for (int k = 1; k <= NS; k++) begin
               mon_c = (m_last + k) % NS;
               if (s_axis_tvalid[mon_c[1:0]]) begin
                  m_gnt = mon_c;
                  m_tid = mon_c[1:0];
                  break;
               end
            end
         end else begin
            mon_g  = m_gnt[1:0];
            mon_er = '0;
            mon_er[mon_g] = m_axis_tready;
            checks++;
            if (busy !== 1'b1 || m_axis_tid !== mon_g || m_axis_tvalid !== s_axis_tvalid[mon_g] ||
                m_axis_tlast !== s_axis_tlast[mon_g] || s_axis_tready !== mon_er) begin
               errors++;
               $display("FAIL grant_outputs t=%0t: busy=%b tid=%0d valid=%b last=%b ready=%b, required 1 tid=%0d valid=%b last=%b ready=%b",
                        $time, busy, m_axis_tid, m_axis_tvalid, m_axis_tlast, s_axis_tready,
                        mon_g, s_axis_tvalid[mon_g], s_axis_tlast[mon_g], mon_er);
            end
            if (s_axis_tvalid[mon_g] && m_axis_tready) begin
               checks++;
               if (exp_q[mon_g].size() == 0) begin
                  errors++;
                  $display("FAIL beat_data t=%0t: beat from source %0d, required none pending", $time, mon_g);
               end else begin
                  mon_e = exp_q[mon_g].pop_front();
                  if (m_axis_tdata !== mon_e[DW-1:0] || m_axis_tlast !== mon_e[DW]) begin
                     errors++;
                     $display("FAIL beat_data t=%0t: src %0d data=%h last=%b, required data=%h last=%b",
                              $time, mon_g, m_axis_tdata, m_axis_tlast, mon_e[DW-1:0], mon_e[DW]);
                  end
               end
               tid_log.push_back(m_gnt);
               data_log.push_back(m_axis_tdata);
               m_cnt++;
               if (s_axis_tlast[mon_g] || (!LOCK && m_cnt == MB)) begin
                  m_last = m_gnt;
                  m_gnt  = -1;
                  m_cnt  = 0;
               end
            end
         end
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      start_reset();
      s_axis_tvalid = '1;
      s_axis_tlast  = '1;
      m_axis_tready = 1'b1;
      #3;
      checks++;
      if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 ||
          s_axis_tready !== 4'b0000 || m_axis_tid !== 2'd0 || dbg_state_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b valid=%b last=%b ready=%b tid=%0d state=%b, required all 0",
                  busy, m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tid, dbg_state_o);
      end
      finish_reset();
      checks++;
      if (busy !== 1'b0 || s_axis_tready !== 4'b0000 || m_axis_tid !== 2'd0) begin
         errors++;
         $display("FAIL reset_release_idle: busy=%b ready=%b tid=%0d, required 0 0000 0",
                  busy, s_axis_tready, m_axis_tid);
      end
   endtask

   task automatic test_round_robin();
      int cyc;
      start_reset();
      finish_reset();
      vprob = 100; rprob = 100; rmode = 1'b0;
      for (int p = 0; p < 3; p++) begin
         for (int s = 0; s < NS; s++) add_pkt(s, 2);
      end
      run_until_drained(200, cyc);
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (k >= tid_log.size() || tid_log[k] != (k / 2) % NS) begin
            errors++;
            $display("FAIL rr_tid_seq[%0d]: got %0d, required %0d", k,
                     (k < tid_log.size()) ? tid_log[k] : -1, (k / 2) % NS);
         end
      end
      // 12 grants of 2 beats plus one bubble each.
      checks++;
      if (cyc != 36) begin
         errors++;
         $display("FAIL rr_cycle_count: took %0d cycles, required 36", cyc);
      end
   endtask

   task automatic test_single_source();
      int cyc;
      logic [DW-1:0] want [3];
      want[0] = 16'h000A; want[1] = 16'h000B; want[2] = 16'h000C;
      start_reset();
      finish_reset();
      vprob = 100; rprob = 100; rmode = 1'b0;
      for (int b = 0; b < 3; b++) add_beat(2, want[b], (b == 2));
      run_until_drained(50, cyc);
      checks++;
      if (data_log.size() != 3 || cyc != 4) begin
         errors++;
         $display("FAIL single_src_count: beats=%0d cycles=%0d, required 3 and 4", data_log.size(), cyc);
      end
      for (int b = 0; b < 3 && b < data_log.size(); b++) begin
         checks++;
         if (data_log[b] !== want[b] || tid_log[b] != 2) begin
            errors++;
            $display("FAIL single_src_beat[%0d]: data=%h tid=%0d, required %h tid=2", b, data_log[b], tid_log[b], want[b]);
         end
      end
   endtask

   task automatic test_burst_interleave();
      int cyc;
      int exp_t[$];
      start_reset();
      finish_reset();
      vprob = 100; rprob = 100; rmode = 1'b0;
      add_pkt(1, 10);
      add_pkt(3, 3);
      add_pkt(3, 3);
      if (LOCK) begin
         repeat (10) exp_t.push_back(1);
         repeat (6)  exp_t.push_back(3);
      end else begin
         repeat (4) exp_t.push_back(1);
         repeat (3) exp_t.push_back(3);
         repeat (4) exp_t.push_back(1);
         repeat (3) exp_t.push_back(3);
         repeat (2) exp_t.push_back(1);
      end
      run_until_drained(100, cyc);
      checks++;
      if (tid_log.size() != exp_t.size()) begin
         errors++;
         $display("FAIL burst_beats: got %0d beats, required %0d", tid_log.size(), exp_t.size());
      end
      for (int k = 0; k < exp_t.size() && k < tid_log.size(); k++) begin
         checks++;
         if (tid_log[k] != exp_t[k]) begin
            errors++;
            $display("FAIL burst_tid[%0d]: got %0d, required %0d", k, tid_log[k], exp_t[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      int n;
      logic [DW-1:0] d0 [6];
      start_reset();
      finish_reset();
      vprob = 100; rmode = 1'b1; tog = 1'b0;
      for (int b = 0; b < 6; b++) begin
         d0[b] = DW'($urandom);
         add_beat(0, d0[b], (b == 5));
      end
      add_pkt(2, 3);
      run_until_drained(200, cyc);
      checks++;
      if (tid_log.size() != 9) begin
         errors++;
         $display("FAIL bp_beat_count: got %0d beats, required 9", tid_log.size());
      end
      n = 0;
      for (int k = 0; k < tid_log.size(); k++) begin
         if (tid_log[k] == 0) begin
            checks++;
            if (n >= 6 || data_log[k] !== d0[n]) begin
               errors++;
               $display("FAIL bp_src0_order[%0d]: data=%h, required %h", n, data_log[k], (n < 6) ? d0[n] : '0);
            end
            n++;
         end
      end
      rmode = 1'b0;
   endtask

   task automatic test_random();
      int cyc;
      int total;
      int len;
      start_reset();
      finish_reset();
      vprob = 60; rprob = 70; rmode = 1'b0;
      total = 0;
      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(1, 7);
         add_pkt($urandom_range(0, NS - 1), len);
         total += len;
      end
      run_until_drained(4000, cyc);
      checks++;
      if (tid_log.size() != total) begin
         errors++;
         $display("FAIL random_beat_count: got %0d beats, required %0d", tid_log.size(), total);
      end
      vprob = 100; rprob = 100;
   endtask

   task automatic test_reset_mid_packet();
      int cyc;
      int guard;
      start_reset();
      finish_reset();
      vprob = 100; rprob = 100; rmode = 1'b0;
      add_pkt(1, 5);
      guard = 0;
      while (tid_log.size() < 1 && guard < 20) begin
         step();
         guard++;
      end
      drive();
      #2;
      checks++;
      if (s_axis_tready !== 4'b0010 || m_axis_tvalid !== 1'b1) begin
         errors++;
         $display("FAIL midpkt_pre_reset: ready=%b valid=%b, required 0010 1", s_axis_tready, m_axis_tvalid);
      end
      mon_en = 1'b0;
      rst    = 1'b1;
      #1;
      checks++;
      if (s_axis_tready !== 4'b0000 || m_axis_tvalid !== 1'b0 || busy !== 1'b0 || m_axis_tid !== 2'd0) begin
         errors++;
         $display("FAIL midpkt_reset_outputs: ready=%b valid=%b busy=%b tid=%0d, required 0000 0 0 0",
                  s_axis_tready, m_axis_tvalid, busy, m_axis_tid);
      end
      start_reset();
      finish_reset();
      add_pkt(3, 2);
      add_pkt(1, 2);
      add_pkt(0, 2);
      run_until_drained(60, cyc);
      checks++;
      if (tid_log.size() == 0 || tid_log[0] != 0) begin
         errors++;
         $display("FAIL midpkt_first_grant: got %0d, required 0", (tid_log.size() > 0) ? tid_log[0] : -1);
      end
   endtask

   initial begin
      rst = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tvalid = '0;
      s_axis_tlast  = '0;
      m_axis_tready = 1'b0;
      model_reset();
      test_reset();
      test_round_robin();
      test_single_source();
      test_burst_interleave();
      test_backpressure();
      test_random();
      test_reset_mid_packet();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
